exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
- Exception initiator at the MEM stage; the producing end of the CP0 exception interface.
- Collects per-instruction exception flags and pending interrupts, then resolves priority.
- Drives excepttype/current_inst_addr/is_in_delayslot/bad_addr into CP0 in the cycle an exception is taken.
- Issues pipeline flush plus redirect PC (handler vector, or forwarded EPC for ERET), then masks new exceptions while the flush drains.

Parameters:
- EXC_VECTOR, 32'hBFC00380: handler entry PC for all non-ERET exceptions.
- FLUSH_CYCLES, 3: total cycles flush_o stays high per taken exception, including the take cycle; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_valid_i  in  1  MEM holds a real instruction; 0 means bubble.
- mem_pc_i  in  32  PC of the MEM instruction.
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot.
- mem_addr_i  in  32  load/store effective address.
- exc_flags_i  in  9  bit0 AdEL-fetch, bit1 RI, bit2 Ov, bit3 Trap, bit4 Sys, bit5 Bp, bit6 Eret, bit7 AdEL-load, bit8 AdES-store.
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values.
- wb_cp0_we_i  in  1  WB-stage CP0 write pending this cycle.
- wb_cp0_waddr_i  in  5  WB CP0 write address.
- wb_cp0_data_i  in  32  WB CP0 write data.
- excepttype_o  out  32  exception code to CP0; 0 = none.
- current_inst_addr_o  out  32  = mem_pc_i.
- is_in_delayslot_o  out  1  = mem_in_delayslot_i.
- bad_addr_o  out  32  faulting address.
- flush_o  out  1  flush IF..MEM.
- new_pc_o  out  32  redirect target; valid while flush_o is high.
- exc_count_o  out  32  taken-exception counter (optional feature).

Behaviour:
- Forwarding, all combinational:
  - status_f = wb_cp0_data_i when wb_cp0_we_i and waddr = 12, else cp0_status_i.
  - epc_f = wb_cp0_data_i when wb_cp0_we_i and waddr = 14, else cp0_epc_i.
  - cause_f = cp0_cause_i with bits[9:8] replaced by wb data[9:8] when waddr = 13 is written.
- Interrupt pending: (cause_f[15:8] & status_f[15:8]) != 0 and status_f[0] = 1 and status_f[1] = 0.
- Detection is active only in state IDLE with mem_valid_i = 1. Otherwise excepttype_o = 0 and all flags are ignored.
- Priority, highest first, with the code emitted on excepttype_o:
  - Int 0x1
  - AdEL-fetch 0x4, bad_addr = mem_pc_i
  - RI 0xa
  - Ov 0xc
  - Trap 0xd
  - Sys 0x8
  - Bp 0x9
  - Eret 0xe
  - AdEL-load 0x4, bad_addr = mem_addr_i
  - AdES-store 0x5, bad_addr = mem_addr_i
- bad_addr_o = 0 for every other code.
- Outputs to CP0 are combinational within the take cycle, so CP0 latches them on that cycle's edge. Latency is 0 cycles from flag to excepttype.
- State machine, states IDLE and HOLD with a 4-bit counter cnt:
  - IDLE, exception taken: flush_o = 1 combinational.
    - new_pc_o = epc_f for Eret, else EXC_VECTOR. The value is registered into pc_hold.
    - If FLUSH_CYCLES > 1: next state HOLD, cnt <= FLUSH_CYCLES-2.
    - Otherwise remain in IDLE.
  - HOLD: flush_o = 1, new_pc_o = pc_hold, excepttype_o = 0.
    - If cnt = 0: next state IDLE, else cnt <= cnt-1.
  - IDLE, no exception: flush_o = 0, new_pc_o = 0.
- Simultaneous events:
  - Multiple flags: only the highest-priority one is reported.
  - Interrupt plus Eret: interrupt wins, EPC goes to mem_pc_i.
  - WB write to EPC in the same cycle as Eret: the forwarded value is used.
  - wb_cp0_we_i with an illegal address: no forwarding.
- Reset, from any state including mid-HOLD:
  - State goes to IDLE, cnt = 0, pc_hold = 0, exc_count_o = 0.
  - While rst = 1: excepttype_o = 0, flush_o = 0, new_pc_o = 0, bad_addr_o = 0.
  - current_inst_addr_o and is_in_delayslot_o remain pass-through.

Optional Feature:
- Macro EXC_COUNT_EN.
- When defined: exc_count_o increments by 1 on every take cycle, Eret included. It saturates at 32'hFFFFFFFF and does not wrap.
- When undefined: no counter flops are built and exc_count_o is tied to 0.

Test Plan:
- Reset, then mem_valid_i = 1 with exc_flags_i = 9'h010 (Sys) at pc 0x80001000 -> same cycle excepttype_o = 0x8 and flush_o = 1, new_pc_o = 0xBFC00380. flush_o stays high 3 cycles total, then drops.
- Flags = 9'h102 (RI + AdES), addr 0x1003 -> excepttype_o = 0xa, bad_addr_o = 0. Repeat with flags = 9'h100 -> excepttype_o = 0x5, bad_addr_o = 0x1003.
- Eret with cp0_epc_i = 0x80000040 while the WB stage writes EPC = 0x80000080 -> new_pc_o = 0x80000080 for all 3 flush cycles.
- cause_i[10] = 1, status_i = 0x00000401, valid instruction with Eret flag, delayslot = 1 -> excepttype_o = 0x1, is_in_delayslot_o = 1. Set status[1] = 1 -> Eret is taken instead (0xe).
- Sys taken, then a Bp flag presented on the next cycle (in HOLD) -> excepttype_o = 0. Assert rst in the second HOLD cycle -> flush_o = 0 next cycle; a Bp after reset is taken with code 0x9.
- With EXC_COUNT_EN defined: 5 exceptions -> exc_count_o = 5. Force the counter to 0xFFFFFFFF and take one more -> it stays 0xFFFFFFFF.

Source files
------------

// File: rtl/exc_ctrl.sv
// Exception initiator at MEM: resolves flag/interrupt priority, drives CP0 and issues flush + redirect PC.
// Optional taken-exception counter is built only when EXC_COUNT_EN is defined.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic [8:0]  exc_flags_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] exc_count_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;
  localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_pc_hold;

  logic [31:0] w_status_f, w_cause_f, w_epc_f;
  logic        w_int_pend, w_detect, w_take;
  logic [31:0] w_code, w_bad, w_target;
  logic        w_unused_ok;

  always_comb begin
    w_status_f = cp0_status_i;
    w_cause_f  = cp0_cause_i;
    w_epc_f    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12:   w_status_f = wb_cp0_data_i;
        5'd13:   w_cause_f[9:8] = wb_cp0_data_i[9:8];
        5'd14:   w_epc_f = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign w_int_pend = (|(w_cause_f[15:8] & w_status_f[15:8])) && w_status_f[0] && !w_status_f[1];
  assign w_unused_ok = &{1'b0, w_cause_f[31:16], w_cause_f[7:0], w_status_f[31:16], w_status_f[7:2]};

  always_comb begin
    w_code = 32'h0;
    w_bad  = 32'h0;
    if (w_int_pend)          w_code = 32'h1;
    else if (exc_flags_i[0]) begin w_code = 32'h4; w_bad = mem_pc_i; end
    else if (exc_flags_i[1]) w_code = 32'ha;
    else if (exc_flags_i[2]) w_code = 32'hc;
    else if (exc_flags_i[3]) w_code = 32'hd;
    else if (exc_flags_i[4]) w_code = 32'h8;
    else if (exc_flags_i[5]) w_code = 32'h9;
    else if (exc_flags_i[6]) w_code = 32'he;
    else if (exc_flags_i[7]) begin w_code = 32'h4; w_bad = mem_addr_i; end
    else if (exc_flags_i[8]) begin w_code = 32'h5; w_bad = mem_addr_i; end
  end

  // An interrupt arriving alongside Eret goes to the vector, not EPC.
  assign w_target = (w_code == 32'he) ? w_epc_f : EXC_VECTOR;
  assign w_detect = !rst && (r_state == S_IDLE) && mem_valid_i;
  assign w_take   = w_detect && (w_code != 32'h0);

  assign excepttype_o        = w_take ? w_code : 32'h0;
  assign bad_addr_o          = w_take ? w_bad  : 32'h0;
  assign current_inst_addr_o = mem_pc_i;
  assign is_in_delayslot_o   = mem_in_delayslot_i;
  assign flush_o             = !rst && ((r_state == S_HOLD) || w_take);

  always_comb begin
    new_pc_o = 32'h0;
    if (!rst) begin
      if (r_state == S_HOLD) new_pc_o = r_pc_hold;
      else if (w_take)       new_pc_o = w_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_pc_hold <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_pc_hold <= w_target;
            if (FLUSH_CYCLES > 1) begin
              r_state <= S_HOLD;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == 4'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  logic [31:0] r_exc_count;

  always_ff @(posedge clk) begin
    if (rst)                                      r_exc_count <= 32'h0;
    else if (w_take && (r_exc_count != 32'hFFFF_FFFF)) r_exc_count <= r_exc_count + 32'h1;
  end

  assign exc_count_o = r_exc_count;
`else
  assign exc_count_o = 32'h0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios then random traffic against a cycle-level reference model.
module tb_exc_ctrl;
  localparam int          FLUSH = 3;
  localparam logic [31:0] VEC   = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_addr_i;
  logic [8:0]  exc_flags_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o, exc_count_o;
  logic        is_in_delayslot_o, flush_o;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: remaining flush cycles, held redirect, exception count.
  int          m_left = 0;
  logic [31:0] m_hold = 32'h0;
  logic [31:0] m_cnt  = 32'h0;

  exc_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i), .mem_addr_i(mem_addr_i),
    .exc_flags_i(exc_flags_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .exc_count_o(exc_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Priority table: first matching rule wins; returns code and faulting address.
  task automatic ref_code(input logic [8:0] fl, input logic ip, input logic [31:0] pc,
                          input logic [31:0] ad, output logic [31:0] code, output logic [31:0] bad);
    int first;
    code = 0;
    bad  = 0;
    first = -1;
    for (int i = 8; i >= 0; i--) if (fl[i]) first = i;
    if (ip) code = 32'h1;
    else begin
      case (first)
        0: begin code = 32'h4; bad = pc; end
        1: code = 32'ha;
        2: code = 32'hc;
        3: code = 32'hd;
        4: code = 32'h8;
        5: code = 32'h9;
        6: code = 32'he;
        7: begin code = 32'h4; bad = ad; end
        8: begin code = 32'h5; bad = ad; end
        default: code = 32'h0;
      endcase
    end
  endtask

  task automatic step();
    logic [31:0] sf, cf, ef, c, b, t;
    logic [31:0] e_code, e_bad, e_pc;
    logic        ip, e_flush, take;
    @(negedge clk);
    sf = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : cp0_status_i;
    ef = (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : cp0_epc_i;
    cf = cp0_cause_i;
    if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) cf[9:8] = wb_cp0_data_i[9:8];
    ip = ((cf[15:8] & sf[15:8]) != 0) && sf[0] && !sf[1];
    ref_code(exc_flags_i, ip, mem_pc_i, mem_addr_i, c, b);
    t = (c == 32'he) ? ef : VEC;
    e_code = 0; e_bad = 0; e_pc = 0; e_flush = 0; take = 0;
    if (!rst) begin
      if (m_left > 0) begin
        e_flush = 1; e_pc = m_hold;
      end else if (mem_valid_i && c != 0) begin
        e_code = c; e_bad = b; e_flush = 1; e_pc = t; take = 1;
      end
    end
    chk("excepttype", excepttype_o, e_code);
    chk("bad_addr", bad_addr_o, e_bad);
    chk("flush", {31'h0, flush_o}, {31'h0, e_flush});
    chk("new_pc", new_pc_o, e_pc);
    chk("inst_addr", current_inst_addr_o, mem_pc_i);
    chk("delayslot", {31'h0, is_in_delayslot_o}, {31'h0, mem_in_delayslot_i});
    chk("exc_count", exc_count_o, m_cnt);
    @(posedge clk);
    #1;
    if (rst) begin
      m_left = 0; m_hold = 0; m_cnt = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (take) begin
      m_left = FLUSH - 1;
      m_hold = t;
`ifdef EXC_COUNT_EN
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
    end
  endtask

  task automatic idle_steps(input int n);
    exc_flags_i = 9'h0;
    wb_cp0_we_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; mem_valid_i = 1'b0; mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0;
    mem_addr_i = 32'h0; exc_flags_i = 9'h0; cp0_status_i = 32'h0; cp0_cause_i = 32'h0;
    cp0_epc_i = 32'h0; wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
    step(); step();
    rst = 1'b0;

    // Sys at 0x80001000: 3-cycle flush to the vector.
    mem_valid_i = 1'b1; mem_pc_i = 32'h80001000; exc_flags_i = 9'h010;
    step();
    idle_steps(3);

    // RI beats AdES; then AdES alone reports the address.
    mem_addr_i = 32'h1003; exc_flags_i = 9'h102;
    step();
    idle_steps(2);
    exc_flags_i = 9'h100;
    step();
    idle_steps(2);

    // Eret with EPC written by WB in the same cycle.
    cp0_epc_i = 32'h80000040; exc_flags_i = 9'h040;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h80000080;
    step();
    idle_steps(2);

    // Interrupt outranks Eret; with EXL set, Eret goes through.
    cp0_cause_i = 32'h00000400; cp0_status_i = 32'h00000401;
    mem_in_delayslot_i = 1'b1; exc_flags_i = 9'h040;
    step();
    idle_steps(2);
    cp0_status_i = 32'h00000403; exc_flags_i = 9'h040;
    step();
    idle_steps(2);
    cp0_cause_i = 32'h0; cp0_status_i = 32'h0; mem_in_delayslot_i = 1'b0;

    // Sys, Bp masked during HOLD, reset mid-HOLD, then Bp taken.
    exc_flags_i = 9'h010;
    step();
    exc_flags_i = 9'h020;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    idle_steps(3);

`ifdef EXC_COUNT_EN
    @(negedge clk);
    force dut.r_exc_count = 32'hFFFF_FFFF;
    #1 release dut.r_exc_count;
    m_cnt = 32'hFFFF_FFFF;
    exc_flags_i = 9'h020;
    step();
    idle_steps(3);
`endif

    for (int n = 0; n < 500; n++) begin
      int r;
      rst = ($urandom_range(0, 59) == 0);
      mem_valid_i = ($urandom_range(0, 3) != 0);
      mem_pc_i = $urandom;
      mem_addr_i = $urandom;
      mem_in_delayslot_i = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 5)      exc_flags_i = 9'h0;
      else if (r < 8) exc_flags_i = 9'(1 << $urandom_range(0, 8));
      else            exc_flags_i = 9'($urandom);
      cp0_status_i = $urandom;
      cp0_cause_i = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
      cp0_epc_i = $urandom;
      wb_cp0_we_i = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      wb_cp0_waddr_i = (r == 0) ? 5'd12 : (r == 1) ? 5'd13 : (r == 2) ? 5'd14 : 5'($urandom);
      wb_cp0_data_i = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
